// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Free-running VGA raster timing generator. Two counters (h_cnt, v_cnt)
//   walk the full raster; every port is a registered decode of the current
//   counter values, so each output lags the counters by exactly one clock.
//   There is no enable and no handshake: the generator runs whenever it is
//   out of reset.
//
//   Optional feature macro: VGA_TIMING_ADDR_EN
//     defined   : oADDR carries a linear pixel address aligned with oBLANK_n.
//     undefined : oADDR is tied to 0 and no address register exists.
//
// Ports
//   iVGA_CLK     in   pixel clock
//   iRST_n       in   asynchronous active-low reset
//   oHS          out  horizontal sync, active-low
//   oVS          out  vertical sync, active-low
//   oBLANK_n     out  high only in the visible region
//   oCurrent_X   out  1..H_ACTIVE when visible, else 0
//   oCurrent_Y   out  1..V_ACTIVE when visible, else 0
//   oLine_start  out  one-cycle pulse for horizontal count 0
//   oFrame_start out  one-cycle pulse for horizontal and vertical count 0
//   oADDR        out  linear pixel address (see macro above)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    output logic        oHS,
    output logic        oVS,
    output logic        oBLANK_n,
    output logic [10:0] oCurrent_X,
    output logic [9:0]  oCurrent_Y,
    output logic        oLine_start,
    output logic        oFrame_start,
    output logic [18:0] oADDR
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HA0     = H_SYNC + H_BACK;
    localparam int VA0     = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] HA0_W    = 11'(HA0);
    localparam logic [10:0] HA_END_W = 11'(HA0 + H_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0]  VA0_W    = 10'(VA0);
    localparam logic [9:0]  VA_END_W = 10'(VA0 + V_ACTIVE);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        ls_q, ls_d;
    logic        fs_q, fs_d;
    logic        h_wrap, vis, first_pix;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        h_cnt_d   = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d   = v_cnt_q;
        // v_cnt steps only on the h_cnt wrap, so both wrap on the same edge.
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end

        vis       = (h_cnt_q >= HA0_W) && (h_cnt_q < HA_END_W) &&
                    (v_cnt_q >= VA0_W) && (v_cnt_q < VA_END_W);
        first_pix = (h_cnt_q == HA0_W) && (v_cnt_q == VA0_W);

        hs_d      = (h_cnt_q >= H_SYNC_W);
        vs_d      = (v_cnt_q >= V_SYNC_W);
        blank_d   = vis;
        // Coordinates are 1-based so that X = 0 / Y = 0 always means blanked.
        x_d       = vis ? (h_cnt_q - HA0_W + 11'd1) : 11'd0;
        y_d       = vis ? (v_cnt_q - VA0_W + 10'd1) : 10'd0;
        ls_d      = (h_cnt_q == 11'd0);
        fs_d      = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign oHS          = hs_q;
    assign oVS          = vs_q;
    assign oBLANK_n     = blank_q;
    assign oCurrent_X   = x_q;
    assign oCurrent_Y   = y_q;
    assign oLine_start  = ls_q;
    assign oFrame_start = fs_q;

`ifdef VGA_TIMING_ADDR_EN
    logic [18:0] addr_q, addr_d;

    // The address restarts at the first visible pixel rather than at frame
    // start, so it keeps showing the last pixel's address through blanking.
    always_comb begin
        addr_d = addr_q;
        if (vis) begin
            addr_d = first_pix ? 19'd0 : addr_q + 19'd1;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign oADDR = addr_q;
`else
    logic unused_first_pix;
    assign unused_first_pix = first_pix;
    assign oADDR            = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Bench for vga_timing_gen using a reduced raster so several full frames
//   and multiple resets fit in a short run. A model process pushes the
//   expected output word for every clock edge into exp_q; a monitor pops
//   and compares each word shortly after the edge. Reset release and
//   mid-frame reset points are randomized.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HS = 4,  HB = 3, HA = 10, HF = 2;
  localparam int VS = 2,  VB = 3, VA = 6,  VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int HA0 = HS + HB;
  localparam int VA0 = VS + VB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [10:0] x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic [18:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_hs, o_vs, o_blank;
  logic [10:0] o_x;
  logic [9:0]  o_y;
  logic        o_ls, o_fs;
  logic [18:0] o_addr;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rst_n),
    .oHS         (o_hs),
    .oVS         (o_vs),
    .oBLANK_n    (o_blank),
    .oCurrent_X  (o_x),
    .oCurrent_Y  (o_y),
    .oLine_start (o_ls),
    .oFrame_start(o_fs),
    .oADDR       (o_addr)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output word for edge k (k >= 1 after release) is
  // the raster decode of pixel-clock index n = k-1.
  int k = 0;
  int exp_addr = 0;

  function automatic exp_t reset_word();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   n, h, v;
    bit   vis;
    if (!rst_n) begin
      k = 0;
      exp_addr = 0;
      exp_q.push_back(reset_word());
    end else begin
      k++;
      n = k - 1;
      h = n % HT;
      v = (n / HT) % VT;
      vis = (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
      e = '0;
      e.hs    = !(h < HS);
      e.vs    = !(v < VS);
      e.blank = vis;
      e.x     = vis ? 11'(h - HA0 + 1) : 11'd0;
      e.y     = vis ? 10'(v - VA0 + 1) : 10'd0;
      e.ls    = (h == 0);
      e.fs    = (h == 0) && (v == 0);
`ifdef VGA_TIMING_ADDR_EN
      if (vis) exp_addr = (v - VA0) * HA + (h - HA0);
      e.addr  = 19'(exp_addr);
`else
      e.addr  = 19'd0;
`endif
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every field after each edge; also measure the
  // line and frame periods between start pulses.
  int  fs_cnt = 0, ls_cnt = 0;
  bit  have_fs = 0, have_ls = 0;
  int  fs_periods = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("oHS",          int'(o_hs),    int'(e.hs));
      check("oVS",          int'(o_vs),    int'(e.vs));
      check("oBLANK_n",     int'(o_blank), int'(e.blank));
      check("oCurrent_X",   int'(o_x),     int'(e.x));
      check("oCurrent_Y",   int'(o_y),     int'(e.y));
      check("oLine_start",  int'(o_ls),    int'(e.ls));
      check("oFrame_start", int'(o_fs),    int'(e.fs));
      check("oADDR",        int'(o_addr),  int'(e.addr));
    end
    if (!rst_n) begin
      have_fs = 0;
      have_ls = 0;
    end else begin
      fs_cnt++;
      ls_cnt++;
      if (o_fs) begin
        if (have_fs) begin
          check("frame_period", fs_cnt, FRAME);
          fs_periods++;
        end
        have_fs = 1;
        fs_cnt = 0;
      end
      if (o_ls) begin
        if (have_ls) check("line_period", ls_cnt, HT);
        have_ls = 1;
        ls_cnt = 0;
      end
    end
  end

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    check("async_oHS",      int'(o_hs),    1);
    check("async_oVS",      int'(o_vs),    1);
    check("async_oBLANK_n", int'(o_blank), 0);
    check("async_X",        int'(o_x),     0);
    check("async_Y",        int'(o_y),     0);
    check("async_ls",       int'(o_ls),    0);
    check("async_fs",       int'(o_fs),    0);
    check("async_oADDR",    int'(o_addr),  0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver / stimulus
  initial begin
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    release_reset();
    // Three full frames, then a reset inside the visible area.
    repeat (3 * FRAME + (VA0 + 3) * HT + HA0 + 5) @(posedge clk);
    async_reset_check();
    repeat ($urandom_range(1, 5)) @(posedge clk);
    release_reset();
    repeat (FRAME + HT + 3) @(posedge clk);
    // Randomly placed resets of random length.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 2 * FRAME)) @(posedge clk);
      async_reset_check();
      repeat ($urandom_range(1, 4)) @(posedge clk);
      release_reset();
    end
    repeat (2 * FRAME + 5) @(posedge clk);
    #2;
    check("frame_periods_seen", int'(fs_periods >= 4), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
